// File: rtl/memory_access.sv
// Memory stage: issues data-bus loads/stores and aligns load data toward writeback.
// Latency: zero added cycles for a same-cycle data_ok; otherwise the access waits in WAIT until data_ok arrives.
// Backpressure: stallM freezes upstream while the access is pending; a response that arrives under freeze is parked in HOLD.
// Optional feature: define MEM_MISALIGN_CHECK_EN to flag non-size-aligned accesses on excM instead of issuing them.

package memory_access_pkg;
  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic [2:0] funct3;
  } ctl_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    ctl_t        ctl;
    logic [4:0]  dst;
    logic [63:0] result;
    logic [63:0] rs2;
  } execute_data_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    ctl_t        ctl;
    logic [4:0]  dst;
    logic [63:0] result;
  } memory_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [1:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module memory_access
  import memory_access_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  execute_data_t dataE,
  input  logic          validE,
  input  logic          freeze,
  output dbus_req_t     dreq,
  input  dbus_resp_t    dresp,
  output memory_data_t  dataM,
  output logic          stallM,
  output logic          excM
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t      state_q;
  logic [63:0] buf_q;

  logic        is_mem;
  logic        mis;
  logic        access;
  logic [5:0]  sh;
  logic [7:0]  base_strobe;
  logic [63:0] raw;
  logic [63:0] shifted;
  logic [63:0] load_val;
  logic        unused_addr_ok;

  assign unused_addr_ok = dresp.addr_ok;

  assign is_mem = validE & (dataE.ctl.memread | dataE.ctl.memwrite);
  assign sh     = {dataE.result[2:0], 3'b000};

`ifdef MEM_MISALIGN_CHECK_EN
  logic misaligned;

  // Address must be a multiple of the access size.
  always_comb begin
    misaligned = 1'b0;
    case (dataE.ctl.funct3[1:0])
      2'd1:    misaligned = dataE.result[0];
      2'd2:    misaligned = |dataE.result[1:0];
      2'd3:    misaligned = |dataE.result[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign mis = is_mem & misaligned;
`else
  assign mis = 1'b0;
`endif

  assign access = is_mem & ~mis;
  assign excM   = mis & reset;

  // Access FSM plus response buffer; a late data_ok in IDLE without a live access is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      buf_q   <= '0;
    end else begin
      case (state_q)
        IDLE, WAIT: begin
          if (access) begin
            if (dresp.data_ok) begin
              if (freeze) begin
                state_q <= HOLD;
                buf_q   <= dresp.data;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              state_q <= WAIT;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        HOLD: begin
          if (!freeze) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Bus request; fields derive from the frozen execute register so they stay stable in WAIT.
  always_comb begin
    case (dataE.ctl.funct3[1:0])
      2'd0:    base_strobe = 8'h01;
      2'd1:    base_strobe = 8'h03;
      2'd2:    base_strobe = 8'h0F;
      default: base_strobe = 8'hFF;
    endcase
    dreq        = '0;
    dreq.valid  = access & (state_q != HOLD) & reset;
    dreq.addr   = dataE.result;
    dreq.size   = dataE.ctl.funct3[1:0];
    dreq.strobe = dataE.ctl.memwrite ? (base_strobe << dataE.result[2:0]) : 8'h00;
    dreq.data   = dataE.ctl.memwrite ? (dataE.rs2 << sh) : 64'd0;
  end

  assign stallM = access & reset & ~dresp.data_ok & (state_q != HOLD);

  // Load alignment and extension; HOLD replays the buffered response.
  always_comb begin
    raw     = (state_q == HOLD) ? buf_q : dresp.data;
    shifted = raw >> sh;
    case (dataE.ctl.funct3)
      3'b000:  load_val = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  load_val = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_val = {{32{shifted[31]}}, shifted[31:0]};
      3'b100:  load_val = {56'd0, shifted[7:0]};
      3'b101:  load_val = {48'd0, shifted[15:0]};
      3'b110:  load_val = {32'd0, shifted[31:0]};
      default: load_val = shifted;
    endcase
  end

  // Result toward writeback: loaded value for live loads, address/ALU result otherwise.
  always_comb begin
    dataM.pc     = dataE.pc;
    dataM.instr  = dataE.instr;
    dataM.ctl    = dataE.ctl;
    dataM.dst    = dataE.dst;
    dataM.result = (access & dataE.ctl.memread) ? load_val : dataE.result;
  end

endmodule
